// File: rtl/simple_fpga_cvs_pkg.sv
// Shared constants and types for the board-level input conditioning logic.
package simple_fpga_cvs_pkg;

  localparam int IO_WIDTH         = 5;
  localparam int CLK_OUT_HZ       = 10_000_000;
  localparam int DEBOUNCE_DEFAULT = 100;

  typedef enum logic {
    DB_STABLE,
    DB_CHANGING
  } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchroniser, persistence counter, edge pulses and a sticky
// event flag with a clear mask.
module debounce_bit
  import simple_fpga_cvs_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic in_async,
  input  logic event_clr,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic event_sticky
);

  logic [SYNC_STAGES-1:0] r_sync;
  db_state_t              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_sticky;

  db_state_t              w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_accept;
  logic                   w_sync;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_sticky_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      DB_STABLE: begin
        if (w_sync != r_level) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_accept = 1'b1;
          end else begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = DB_CHANGING;
          end
        end
      end
      DB_CHANGING: begin
        if (w_sync == r_level) begin
          // Glitch ended before persisting long enough: discard it silently.
          w_cnt_nxt   = '0;
          w_state_nxt = DB_STABLE;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          w_accept = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = DB_STABLE;
      end
    endcase
    if (w_accept) begin
      w_cnt_nxt   = '0;
      w_state_nxt = DB_STABLE;
    end
  end

  assign w_rise_nxt   = w_accept & w_sync;
  assign w_fall_nxt   = w_accept & ~w_sync;
  // A new edge wins over a simultaneous clear so no event is dropped.
  assign w_sticky_nxt = (r_sticky & ~event_clr) | w_rise_nxt | w_fall_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_state  <= DB_STABLE;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], in_async};
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_accept ? w_sync : r_level;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  assign level_out    = r_level;
  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign event_sticky = r_sticky;

endmodule

// File: rtl/gpio_debounce.sv
// Conditions the asynchronous board inputs: each bit gets its own
// synchroniser and debounce filter; bits are fully independent.
module gpio_debounce
  import simple_fpga_cvs_pkg::*;
#(
  parameter int WIDTH           = IO_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_async,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] event_sticky,
  input  logic [WIDTH-1:0] event_clr
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk         (clk),
      .rst         (rst),
      .in_async    (in_async[b]),
      .event_clr   (event_clr[b]),
      .level_out   (level_out[b]),
      .rise_pulse  (rise_pulse[b]),
      .fall_pulse  (fall_pulse[b]),
      .event_sticky(event_sticky[b])
    );
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: directed scenarios plus random pin activity,
// compared every cycle against a sliding-window reference model.
module tb_gpio_debounce;

  localparam int W = 5;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_async = 5'b10101;
  logic [W-1:0] event_clr = '0;
  logic [W-1:0] level_out, rise_pulse, fall_pulse, event_sticky;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  gpio_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_async    (in_async),
    .level_out   (level_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .event_sticky(event_sticky),
    .event_clr   (event_clr)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a pin value reaches the filter S edges later; the level
  // flips when the last D filter samples all disagree with the current level.
  logic [W-1:0] m_pipe [S];
  logic [D-1:0] m_hist [W];
  logic [W-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_sticky = '0;

  always @(posedge clk) begin
    logic [W-1:0] s, nl, nr, nf;
    logic [D-1:0] h;
    logic         acc;
    if (rst) begin
      for (int i = 0; i < S; i++) m_pipe[i] <= '0;
      for (int b = 0; b < W; b++) m_hist[b] <= '0;
      m_level  <= '0;
      m_rise   <= '0;
      m_fall   <= '0;
      m_sticky <= '0;
    end else begin
      s  = m_pipe[S-1];
      nl = m_level;
      nr = '0;
      nf = '0;
      for (int b = 0; b < W; b++) begin
        h   = {m_hist[b][D-2:0], s[b]};
        acc = (h == {D{~m_level[b]}});
        if (acc) begin
          nl[b] = s[b];
          nr[b] = s[b];
          nf[b] = ~s[b];
        end
        m_hist[b] <= h;
      end
      m_level  <= nl;
      m_rise   <= nr;
      m_fall   <= nf;
      m_sticky <= (m_sticky & ~event_clr) | nr | nf;
      for (int i = S - 1; i > 0; i--) m_pipe[i] <= m_pipe[i-1];
      m_pipe[0] <= in_async;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", level_out, m_level);
      chk("rise", rise_pulse, m_rise);
      chk("fall", fall_pulse, m_fall);
      chk("sticky", event_sticky, m_sticky);
      chk("rise_and_fall", rise_pulse & fall_pulse, '0);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int n;
    bit saw_r, saw_f;

    // Reset with pins already high on alternate bits.
    step(1);
    chk_en = 1'b1;
    chk("rst_level", level_out, '0);
    chk("rst_rise", rise_pulse, '0);
    chk("rst_sticky", event_sticky, '0);
    step(2);
    chk("rst_level_held", level_out, '0);
    rst = 1'b0;
    step(5);
    chk("por_level_c5", level_out, '0);
    step(1);
    chk("por_level_c6", level_out, 5'b10101);
    chk("por_rise_c6", rise_pulse, 5'b10101);
    chk("por_sticky_c6", event_sticky, 5'b10101);
    step(1);
    chk("por_rise_gone", rise_pulse, '0);

    // Drop everything and clear the flags.
    in_async  = '0;
    event_clr = '1;
    step(10);
    event_clr = '0;
    chk("quiet_level", level_out, '0);
    chk("quiet_sticky", event_sticky, '0);

    // Clean rising edge on bit 0: expect 6 edges from the pin change.
    in_async[0] = 1'b1;
    n = 0;
    while (!level_out[0] && n < 20) begin
      step(1);
      n++;
    end
    chk("clean_latency", n, 6);
    chk("clean_rise0", rise_pulse[0], 1'b1);
    chk("clean_fall0", fall_pulse[0], 1'b0);
    step(1);
    chk("clean_rise0_once", rise_pulse[0], 1'b0);

    // Three-cycle glitch on bit 2 must be rejected.
    in_async[2] = 1'b1;
    step(3);
    in_async[2] = 1'b0;
    saw_r = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (level_out[2] || rise_pulse[2] || event_sticky[2]) saw_r = 1'b1;
    end
    chk("glitch_rejected", saw_r, 1'b0);

    // Four-cycle pulse on bit 4 is just long enough, and its fall follows.
    in_async[4] = 1'b1;
    step(4);
    in_async[4] = 1'b0;
    saw_r = 1'b0;
    saw_f = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (rise_pulse[4]) saw_r = 1'b1;
      if (fall_pulse[4] && saw_r) saw_f = 1'b1;
    end
    chk("boundary_rise4", saw_r, 1'b1);
    chk("boundary_fall4", saw_f, 1'b1);

    // Clear racing a fall on bit 1: the set wins, a later clear takes effect.
    in_async[1] = 1'b1;
    step(10);
    in_async[1] = 1'b0;
    step(5);
    event_clr[1] = 1'b1;
    step(1);
    chk("race_fall1", fall_pulse[1], 1'b1);
    chk("race_sticky1", event_sticky[1], 1'b1);
    step(1);
    event_clr[1] = 1'b0;
    chk("race_cleared1", event_sticky[1], 1'b0);

    // Reset in the middle of a bit 3 debounce.
    in_async = '0;
    step(10);
    in_async[3] = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_level3", level_out[3], 1'b0);
    chk("midrst_rise3", rise_pulse[3], 1'b0);
    n = 0;
    while (!level_out[3] && n < 20) begin
      step(1);
      n++;
      if (!level_out[3] && rise_pulse[3]) n = 100;
    end
    chk("midrst_restart", n, 6);

    // Random pin activity, clears and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) in_async[b] = ~in_async[b];
      event_clr = ($urandom_range(0, 6) == 0) ? W'($urandom) : '0;
      rst       = ($urandom_range(0, 255) == 0);
      step(1);
    end
    rst = 1'b0;
    event_clr = '0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_debounce.md
Name: gpio_debounce

Overview:
- Conditions the 5 asynchronous board inputs before they reach design logic.
- Sits between the board input pins and the logic that currently receives the raw `in` bus. Runs in the 10 MHz MMCM output clock domain (300 MHz × 2 / 60).
- Per bit, it synchronises the input, filters glitches with a debounce counter, and produces:
  - a clean level,
  - single-cycle rise/fall pulses,
  - sticky event flags with a clear handshake.

Parameters:
- WIDTH, 5: number of input bits.
- SYNC_STAGES, 2: synchroniser flop depth per bit. Must be >= 2.
- DEBOUNCE_CYCLES, 100: consecutive cycles a changed synchronised value must persist before it is accepted (10 us at 10 MHz). Must be >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; not to be overridden.

Ports:
- clk  in  1  10 MHz clock from the MMCM CLKOUT0.
- rst  in  1  reset, synchronous, active-high.
- in_async  in  WIDTH  raw pin inputs; asynchronous to clk.
- level_out  out  WIDTH  debounced level per bit.
- rise_pulse  out  WIDTH  1-cycle pulse when level_out goes 0->1.
- fall_pulse  out  WIDTH  1-cycle pulse when level_out goes 1->0.
- event_sticky  out  WIDTH  latched "any edge seen" flag per bit.
- event_clr  in  WIDTH  per-bit clear mask for event_sticky, sampled each cycle.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). All flops update only on the rising edge of clk.
- Reset values (on any cycle with rst=1):
  - all synchroniser flops = 0, level_out = 0, counters = 0;
  - rise_pulse = 0, fall_pulse = 0, event_sticky = 0.
  - rst has priority over every other input. Assertion mid-debounce abandons the count, and no pulse is issued for it.
- Synchroniser: sync[b] is the output of a SYNC_STAGES-deep flop chain on in_async[b]. No logic between stages.
- Per-bit debounce, two states:
  - STABLE (counter = 0):
    - if sync[b] == level_out[b], stay;
    - else counter <= 1 and go to CHANGING. If DEBOUNCE_CYCLES == 1, accept immediately instead (see accept).
  - CHANGING:
    - if sync[b] == level_out[b] (glitch ended), counter <= 0 and go to STABLE, with no output change;
    - else if counter == DEBOUNCE_CYCLES-1, accept;
    - else counter <= counter + 1.
  - Accept: level_out[b] <= sync[b], counter <= 0, go to STABLE. On the same edge, rise_pulse[b] <= sync[b] and fall_pulse[b] <= ~sync[b].
  - The counter never exceeds DEBOUNCE_CYCLES-1. There is no wrap-around.
- Latency:
  - If sync[b] first differs from level_out[b] in cycle k and keeps differing, level_out[b] changes in cycle k + DEBOUNCE_CYCLES.
  - Measured from the pin: SYNC_STAGES + DEBOUNCE_CYCLES cycles (±1 for the asynchronous sampling edge).
  - Pulses are registered and coincide with the cycle level_out changes.
- Pulses: high for exactly 1 cycle. rise_pulse[b] and fall_pulse[b] are never both high.
- Sticky flags:
  - event_sticky[b] <= (event_sticky[b] & ~event_clr[b]) | rise_pulse_next[b] | fall_pulse_next[b].
  - A set and a clear on the same edge: set wins, so no event is lost.
  - Clearing an already-clear bit has no effect.
- Power-up with a pin held high: after rst drops, level_out rises after SYNC_STAGES + DEBOUNCE_CYCLES cycles, and rise_pulse fires once. This is intended; consumers ignore the first event after reset if required.
- Bits are fully independent. Simultaneous events on different bits are all reported in the same cycle.

Decomposition:
- Package simple_fpga_cvs_pkg holds:
  - IO_WIDTH = 5;
  - CLK_OUT_HZ = 10_000_000;
  - DEBOUNCE_DEFAULT = 100;
  - the per-bit state enum {DB_STABLE, DB_CHANGING}.
- Sub-module debounce_bit contains the synchroniser, counter, FSM, pulses and sticky flag for one bit. It is instantiated WIDTH times in a generate loop.
- gpio_debounce itself only fans bits out and in.

Test Plan (bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset: hold rst 3 cycles with in_async=5'b10101 -> all outputs 0 during reset. After release, level_out=5'b10101 appears at cycle 6, rise_pulse=5'b10101 for 1 cycle, event_sticky=5'b10101.
- Clean edge: in_async[0] 0->1 held -> level_out[0] rises 6 cycles after the pin change (±1). rise_pulse[0] is high exactly 1 cycle; fall_pulse stays 0.
- Glitch reject: in_async[2] high for 3 cycles then low -> level_out[2], rise_pulse[2] and event_sticky[2] all remain 0. The internal counter returns to 0.
- Boundary acceptance:
  - high for exactly 4 synced cycles -> accepted;
  - high for 3 synced cycles -> rejected;
  - for a 4-cycle pulse, fall follows 4 cycles after the synced low.
- Sticky clear race: assert event_clr[1] on the same cycle that fall_pulse[1] is generated -> event_sticky[1] stays 1. A clear one cycle later sets it to 0.
- Mid-debounce reset: assert rst while counter[3]=2 -> no pulse, level_out[3]=0. The count restarts from 0 after release.
